// File: rtl/dwt97_pkg.sv
// Shared definitions for the 9/7 DWT lifting datapath.
//
// Coefficient : default real-valued CDF 9/7 lifting coefficients.
// dwt97_pkg   : pair_t {eol, sof, even, odd}, FSM state encoding and the
//               helper that turns a real coefficient into a fixed-point
//               integer with a given number of fractional bits.

package Coefficient;
    localparam real Alpha = -1.586134342059924;
    localparam real Beta  = -0.052980118572961;
endpackage

package dwt97_pkg;

    // Coefficient width carried by pair_t; the row stages are built at this width.
    localparam int PairWidth = 16;

    typedef struct packed {
        logic                        eol;
        logic                        sof;
        logic signed [PairWidth-1:0] even;
        logic signed [PairWidth-1:0] odd;
    } pair_t;

    typedef enum logic [1:0] {
        LINE_START = 2'd0,
        RUN        = 2'd1,
        FLUSH      = 2'd2
    } lift_state_t;

    // Truncates toward zero, matching $rtoi semantics.
    function automatic int fixed_coef(input real coef, input int point);
        return $rtoi(coef * (2.0 ** point));
    endfunction

endpackage

// File: rtl/lift_term.sv
// Combinational lifting term L(a, b, K) = trunc_Width(floor(((a + b) * K) / 2^Point)).
//
// Ports:
//   a_i, b_i : signed Width-bit operands
//   term_o   : signed Width-bit lifting term (two's-complement wrap)

module lift_term #(
    parameter int Width = 16,
    parameter int Point = 10,
    parameter int K     = 0
) (
    input  logic signed [Width-1:0] a_i,
    input  logic signed [Width-1:0] b_i,
    output logic signed [Width-1:0] term_o
);

    localparam logic signed [31:0] KS = K;

    logic signed [Width:0]    w_sum;
    logic signed [Width+32:0] w_prod;
    logic                     w_unused_prod;

    // One guard bit keeps the sum exact before scaling.
    assign w_sum  = a_i + b_i;
    assign w_prod = w_sum * KS;

    // Selecting bits [Point +: Width] is an arithmetic shift right by Point
    // (floor) followed by truncation to Width bits.
    assign term_o = w_prod[Point +: Width];

    assign w_unused_prod = ^w_prod;

endmodule

// File: rtl/inverse_lifting_row.sv
// Inverse 9/7 lifting step along an image row.
//
// Undoes one forward predict/update pair:
//   x_even[n] = y_even[n] - L(y_odd[n-1], y_odd[n], KB)
//   x_odd[n]  = y_odd[n]  - L(x_even[n], x_even[n+1], KA)
// with symmetric extension at both line ends. Two instances with different
// Alpha/Beta cascade into the full row inverse transform.
//
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   s_valid_i/s_ready_o   : input handshake
//   s_sof_i/s_eol_i       : first / last pair of the incoming line
//   s_data_i              : {odd, even} transformed pair
//   m_valid_o/m_ready_i   : output handshake
//   m_sof_o/m_eol_o       : first / last pair of the emitted line
//   m_data_o              : {odd, even} reconstructed pair

module inverse_lifting_row
    import dwt97_pkg::*;
#(
    parameter int  DataWidth = PairWidth,
    parameter int  Point     = 10,
    parameter real Alpha     = Coefficient::Alpha,
    parameter real Beta      = Coefficient::Beta
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   s_ready_o,
    input  logic                   s_valid_i,
    input  logic                   s_sof_i,
    input  logic                   s_eol_i,
    input  logic [2*DataWidth-1:0] s_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [2*DataWidth-1:0] m_data_o
);

    localparam int KA = fixed_coef(Alpha, Point);
    localparam int KB = fixed_coef(Beta, Point);

    lift_state_t r_state;
    lift_state_t w_next_state;

    pair_t r_held;
    pair_t r_out;
    pair_t w_held_next;
    pair_t w_out_next;
    logic  r_m_valid;
    logic  w_load_held;
    logic  w_load_out;

    logic signed [DataWidth-1:0] w_in_odd;
    logic signed [DataWidth-1:0] w_in_even;
    logic signed [DataWidth-1:0] w_odd_prev;
    logic signed [DataWidth-1:0] w_term_b;
    logic signed [DataWidth-1:0] w_x_even;
    logic signed [DataWidth-1:0] w_a_left;
    logic signed [DataWidth-1:0] w_a_right;
    logic signed [DataWidth-1:0] w_odd_src;
    logic signed [DataWidth-1:0] w_term_a;
    logic signed [DataWidth-1:0] w_x_odd;

    logic w_out_free;
    logic w_accept;
    logic w_line_start;

    assign {w_in_odd, w_in_even} = s_data_i;

    assign w_out_free = !r_m_valid || m_ready_i;
    assign s_ready_o  = (r_state != FLUSH) && w_out_free;
    assign w_accept   = s_valid_i && s_ready_o;

    // A sof arriving mid-line means the previous line lost its eol: the held
    // pair is abandoned and this beat restarts the line.
    assign w_line_start = (r_state == LINE_START) || ((r_state == RUN) && s_sof_i);

    // At a line start y_odd[-1] mirrors to y_odd[0].
    assign w_odd_prev = w_line_start ? w_in_odd : r_held.odd;

    lift_term #(
        .Width(DataWidth),
        .Point(Point),
        .K    (KB)
    ) u_term_b (
        .a_i   (w_odd_prev),
        .b_i   (w_in_odd),
        .term_o(w_term_b)
    );

    assign w_x_even = w_in_even - w_term_b;

    // Operand select for the predict term. The default covers FLUSH, where the
    // right neighbour mirrors (x_even[n+1] = x_even[n]).
    always_comb begin
        w_a_left  = r_held.even;
        w_a_right = r_held.even;
        w_odd_src = r_held.odd;
        if (w_line_start) begin
            w_a_left  = w_x_even;
            w_a_right = w_x_even;
            w_odd_src = w_in_odd;
        end else if (r_state == RUN) begin
            w_a_right = w_x_even;
        end
    end

    lift_term #(
        .Width(DataWidth),
        .Point(Point),
        .K    (KA)
    ) u_term_a (
        .a_i   (w_a_left),
        .b_i   (w_a_right),
        .term_o(w_term_a)
    );

    assign w_x_odd = w_odd_src - w_term_a;

    always_comb begin
        w_next_state = r_state;
        w_load_held  = 1'b0;
        w_load_out   = 1'b0;
        w_held_next  = r_held;
        w_out_next   = r_out;
        case (r_state)
            LINE_START, RUN: begin
                if (w_accept) begin
                    w_load_held      = 1'b1;
                    w_held_next.eol  = s_eol_i;
                    w_held_next.even = w_x_even;
                    w_held_next.odd  = w_in_odd;
                    if (w_line_start) begin
                        w_held_next.sof = s_sof_i;
                        if (s_eol_i) begin
                            // Single-pair line leaves straight away.
                            w_load_out      = 1'b1;
                            w_out_next.eol  = 1'b1;
                            w_out_next.sof  = s_sof_i;
                            w_out_next.even = w_x_even;
                            w_out_next.odd  = w_x_odd;
                            w_next_state    = LINE_START;
                        end else begin
                            w_next_state = RUN;
                        end
                    end else begin
                        w_held_next.sof = 1'b0;
                        w_load_out      = 1'b1;
                        w_out_next.eol  = 1'b0;
                        w_out_next.sof  = r_held.sof;
                        w_out_next.even = r_held.even;
                        w_out_next.odd  = w_x_odd;
                        w_next_state    = s_eol_i ? FLUSH : RUN;
                    end
                end
            end
            FLUSH: begin
                if (w_out_free) begin
                    w_load_out      = 1'b1;
                    w_out_next.eol  = r_held.eol;
                    w_out_next.sof  = r_held.sof;
                    w_out_next.even = r_held.even;
                    w_out_next.odd  = w_x_odd;
                    w_next_state    = LINE_START;
                end
            end
            default: begin
                w_next_state = LINE_START;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= LINE_START;
            r_held  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_held) begin
                r_held <= w_held_next;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out     <= '0;
            r_m_valid <= 1'b0;
        end else if (w_load_out) begin
            r_out     <= w_out_next;
            r_m_valid <= 1'b1;
        end else if (m_ready_i) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid_o = r_m_valid;
    assign m_sof_o   = r_out.sof;
    assign m_eol_o   = r_out.eol;
    assign m_data_o  = {r_out.odd, r_out.even};

endmodule

// File: tb/tb_inverse_lifting_row.sv
// Directed self-checking bench for inverse_lifting_row with Alpha=-0.5,
// Beta=0.25, Point=10, DataWidth=16 (KA=-512, KB=256).

module tb_inverse_lifting_row;

    localparam int KA = -512;
    localparam int KB = 256;

    logic        clock;
    logic        reset;
    logic        sReady;
    logic        sValid;
    logic        sSof;
    logic        sEol;
    logic [31:0] sData;
    logic        mReady;
    logic        mValid;
    logic        mSof;
    logic        mEol;
    logic [31:0] mData;

    int testsRun;
    int testsFailed;

    logic [33:0] outQ[$];

    int yOdd[64];
    int yEven[64];
    int xOdd[64];
    int xEven[64];
    int expOdd[64];
    int expEven[64];

    inverse_lifting_row #(
        .DataWidth(16),
        .Point    (10),
        .Alpha    (-0.5),
        .Beta     (0.25)
    ) dut (
        .clk_i    (clock),
        .rst_i    (reset),
        .s_ready_o(sReady),
        .s_valid_i(sValid),
        .s_sof_i  (sSof),
        .s_eol_i  (sEol),
        .s_data_i (sData),
        .m_ready_i(mReady),
        .m_valid_o(mValid),
        .m_sof_o  (mSof),
        .m_eol_o  (mEol),
        .m_data_o (mData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every completed output transfer, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset && mValid && mReady) begin
            outQ.push_back({mSof, mEol, mData});
        end
    end

    function automatic int wrap16(input longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int lterm(input int a, input int b, input int k);
        longint p;
        p = longint'(a + b) * longint'(k);
        p = p >>> 10;
        return wrap16(p);
    endfunction

    function automatic logic [31:0] pk(input int o, input int e);
        return {o[15:0], e[15:0]};
    endfunction

    function automatic void invModel(input int n);
        for (int i = 0; i < n; i++) begin
            expEven[i] = wrap16(longint'(yEven[i] - lterm((i == 0) ? yOdd[0] : yOdd[i-1], yOdd[i], KB)));
        end
        for (int i = 0; i < n; i++) begin
            expOdd[i] = wrap16(longint'(yOdd[i] - lterm(expEven[i], (i == n-1) ? expEven[i] : expEven[i+1], KA)));
        end
    endfunction

    function automatic void fwdModel(input int n);
        for (int i = 0; i < n; i++) begin
            yOdd[i] = wrap16(longint'(xOdd[i] + lterm(xEven[i], (i == n-1) ? xEven[i] : xEven[i+1], KA)));
        end
        for (int i = 0; i < n; i++) begin
            yEven[i] = wrap16(longint'(xEven[i] + lterm((i == 0) ? yOdd[0] : yOdd[i-1], yOdd[i], KB)));
        end
    endfunction

    task automatic fail(input string name, input logic [63:0] actual, input logic [63:0] required);
        testsFailed++;
        $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    endtask

    // Call at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic sendPair(input int o, input int e, input logic sof, input logic eol);
        int guard;
        guard  = 0;
        sValid = 1'b1;
        sData  = pk(o, e);
        sSof   = sof;
        sEol   = eol;
        @(negedge clock);
        while (!sReady && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!sReady) begin
            testsRun++;
            fail("send_timeout", 64'(guard), 64'd0);
        end
        @(posedge clock);
        #1;
        sValid = 1'b0;
        sSof   = 1'b0;
        sEol   = 1'b0;
    endtask

    task automatic sendLine(input int n);
        for (int i = 0; i < n; i++) begin
            sendPair(yOdd[i], yEven[i], i == 0, i == n-1);
        end
    endtask

    task automatic waitOutputs(input int n, input string name);
        int guard;
        guard = 0;
        while (outQ.size() < n && guard < 300) begin
            @(posedge clock);
            guard++;
        end
        #1;
        if (outQ.size() < n) begin
            testsRun++;
            fail(name, 64'(outQ.size()), 64'(n));
        end
    endtask

    task automatic checkLine(input int n, input string name);
        logic [33:0] want;
        waitOutputs(n, name);
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < n; i++) begin
            if (i < outQ.size()) begin
                want = {(i == 0), (i == n-1), pk(expOdd[i], expEven[i])};
                testsRun++;
                if (outQ[i] !== want) fail({name, "_pair"}, 64'(outQ[i]), 64'(want));
            end
        end
        testsRun++;
        if (outQ.size() != n) fail({name, "_count"}, 64'(outQ.size()), 64'(n));
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        sValid = 1'b0;
        sSof   = 1'b0;
        sEol   = 1'b0;
        sData  = '0;
        mReady = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        testsRun++;
        if ({mValid, mSof, mEol} !== 3'b000) fail("reset_flags", 64'({mValid, mSof, mEol}), 64'd0);
        testsRun++;
        if (mData !== 32'd0) fail("reset_data", 64'(mData), 64'd0);
        testsRun++;
        if (sReady !== 1'b1) fail("reset_ready", 64'(sReady), 64'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_two_pair();
        outQ.delete();
        sendPair(4, 10, 1'b1, 1'b0);
        sendPair(8, 20, 1'b0, 1'b1);
        testsRun++;
        if ({sReady, mValid, mSof, mEol, mData} !== {4'b0110, pk(17, 8)})
            fail("two_pair_first", 64'({sReady, mValid, mSof, mEol, mData}), 64'({4'b0110, pk(17, 8)}));
        @(posedge clock);
        #1;
        testsRun++;
        if ({sReady, mValid, mSof, mEol, mData} !== {4'b1101, pk(25, 17)})
            fail("two_pair_last", 64'({sReady, mValid, mSof, mEol, mData}), 64'({4'b1101, pk(25, 17)}));
        @(posedge clock);
        #1;
        testsRun++;
        if (mValid !== 1'b0) fail("two_pair_idle", 64'(mValid), 64'd0);
    endtask

    task automatic test_single_pair();
        sendPair(4, 10, 1'b1, 1'b1);
        testsRun++;
        if ({sReady, mValid, mSof, mEol, mData} !== {4'b1111, pk(12, 8)})
            fail("single_pair", 64'({sReady, mValid, mSof, mEol, mData}), 64'({4'b1111, pk(12, 8)}));
        @(posedge clock);
        #1;
    endtask

    task automatic test_backpressure();
        int odds[8]  = '{3, -7, 12, 0, 25, -4, 9, 1};
        int evens[8] = '{100, -50, 30, 7, -200, 64, 5, -1};
        for (int i = 0; i < 8; i++) begin
            yOdd[i]  = odds[i];
            yEven[i] = evens[i];
        end
        invModel(8);
        outQ.delete();
        fork
            sendLine(8);
            begin
                repeat (4) @(posedge clock);
                #1;
                mReady = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clock);
                    testsRun++;
                    if ({mValid, sReady, mData} !== {2'b10, pk(expOdd[2], expEven[2])})
                        fail("stall_hold", 64'({mValid, sReady, mData}), 64'({2'b10, pk(expOdd[2], expEven[2])}));
                    @(posedge clock);
                    #1;
                end
                mReady = 1'b1;
            end
        join
        checkLine(8, "backpressure");
    endtask

    task automatic test_reset_midline();
        sendPair(4, 10, 1'b1, 1'b0);
        sendPair(8, 20, 1'b0, 1'b0);
        sendPair(1, 2, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        testsRun++;
        if ({mValid, sReady} !== 2'b01) fail("async_reset", 64'({mValid, sReady}), 64'b01);
        @(posedge clock);
        #1;
        reset = 1'b0;
        outQ.delete();
        yOdd[0]  = 4;
        yEven[0] = 10;
        yOdd[1]  = 8;
        yEven[1] = 20;
        expOdd[0]  = 17;
        expEven[0] = 8;
        expOdd[1]  = 25;
        expEven[1] = 17;
        sendLine(2);
        checkLine(2, "after_reset");
    endtask

    task automatic test_wrap();
        sendPair(0, -32768, 1'b1, 1'b1);
        testsRun++;
        if ($isunknown(mData) || mData !== 32'h8000_8000 || mValid !== 1'b1)
            fail("wrap", 64'({mValid, mData}), 64'({1'b1, 32'h8000_8000}));
        @(posedge clock);
        #1;
    endtask

    task automatic test_round_trip();
        int dOdd;
        int dEven;
        logic signed [15:0] gotOdd;
        logic signed [15:0] gotEven;
        for (int i = 0; i < 64; i++) begin
            xOdd[i]  = int'($urandom_range(2000)) - 1000;
            xEven[i] = int'($urandom_range(2000)) - 1000;
        end
        fwdModel(64);
        outQ.delete();
        sendLine(64);
        waitOutputs(64, "round_trip_timeout");
        for (int i = 0; i < 64; i++) begin
            if (i < outQ.size()) begin
                gotOdd  = outQ[i][31:16];
                gotEven = outQ[i][15:0];
                dOdd    = int'(gotOdd) - xOdd[i];
                dEven   = int'(gotEven) - xEven[i];
                testsRun++;
                if (dOdd > 2 || dOdd < -2 || dEven > 2 || dEven < -2 || outQ[i][33] !== (i == 0) || outQ[i][32] !== (i == 63))
                    fail("round_trip", 64'(outQ[i]), 64'({(i == 0), (i == 63), pk(xOdd[i], xEven[i])}));
            end
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_two_pair();
        test_single_pair();
        test_backpressure();
        test_reset_midline();
        test_wrap();
        test_round_trip();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
